// File: rtl/ring_osc_counter.sv
`timescale 1ps/1ps
// ring_osc_counter: gated ring oscillator, ring-edge counter and an i_clk-domain
// measurement controller (CLEAR -> RUN for G cycles -> SETTLE -> CAPTURE).
// Optional feature macro: RO_OVERFLOW_EN (saturating edge counter plus o_overflow).
// Stage delays exist only outside SYNTHESIS; a synthesis build gets a plain ring.
module ring_osc_counter #(
   parameter int unsigned LENGTH         = 9,
   parameter int unsigned COUNT_WIDTH    = 12,
   parameter int unsigned GATE_WIDTH     = 8,
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned STAGE_DELAY_PS = 100
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic [GATE_WIDTH-1:0]  i_gate_cycles,
   input  logic                   i_continuous,
   output logic                   o_busy,
   output logic                   o_valid,
   output logic [COUNT_WIDTH-1:0] o_count,
`ifdef RO_OVERFLOW_EN
   output logic                   o_overflow,
`endif
   output logic                   o_ring_en,
   output logic                   o_pulse
);

   localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {StIdle, StClear, StRun, StSettle, StCapture} state_e;

   state_e                 state_q, state_d;
   logic [GATE_WIDTH-1:0]  gate_cnt_q, gate_cnt_d;
   logic [SW-1:0]          settle_cnt_q, settle_cnt_d;
   logic                   ring_en_q;
   logic                   ring_clr_q;
   logic                   valid_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] edge_cnt_q;
   logic [LENGTH-1:0]      ring;
`ifdef RO_OVERFLOW_EN
   logic                   overflow_q;
`endif

   // Next-state logic; G is (re)latched straight into the gate down-counter.
   always_comb begin
      state_d      = state_q;
      gate_cnt_d   = gate_cnt_q;
      settle_cnt_d = settle_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (i_start && (i_gate_cycles != '0)) begin
               gate_cnt_d = i_gate_cycles;
               state_d    = StClear;
            end
         end
         StClear: state_d = StRun;
         StRun: begin
            if (gate_cnt_q == GATE_WIDTH'(1)) begin
               settle_cnt_d = SW'(SETTLE_CYCLES);
               state_d      = StSettle;
            end else begin
               gate_cnt_d = gate_cnt_q - GATE_WIDTH'(1);
            end
         end
         StSettle: begin
            if (settle_cnt_q == SW'(1)) begin
               state_d = StCapture;
            end else begin
               settle_cnt_d = settle_cnt_q - SW'(1);
            end
         end
         StCapture: begin
            // A zero window on re-latch ends the continuous sequence.
            if (i_continuous && (i_gate_cycles != '0)) begin
               gate_cnt_d = i_gate_cycles;
               state_d    = StClear;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, registered ring controls and capture of the settled edge count.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= StIdle;
         gate_cnt_q   <= '0;
         settle_cnt_q <= '0;
         ring_en_q    <= 1'b0;
         ring_clr_q   <= 1'b1;
         valid_q      <= 1'b0;
         count_q      <= '0;
`ifdef RO_OVERFLOW_EN
         overflow_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         gate_cnt_q   <= gate_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         ring_en_q    <= (state_d == StRun);
         ring_clr_q   <= (state_d == StClear);
         valid_q      <= (state_d == StCapture);
         if (state_d == StCapture) begin
            count_q    <= edge_cnt_q;
`ifdef RO_OVERFLOW_EN
            overflow_q <= (edge_cnt_q == '1);
`endif
         end
      end
   end

   // Ring: stage 0 is the enable NAND, the rest are inverters.
   for (genvar i = 0; i < LENGTH; i++) begin : g_stage
      logic stage_in;
      logic stage_out;
      if (i == 0) begin : g_nand
         assign stage_in = ~(ring_en_q & ring[LENGTH-1]);
      end else begin : g_inv
         assign stage_in = ~ring[i-1];
      end
`ifdef SYNTHESIS
      assign stage_out = stage_in;
`else
      // Transport delay per stage; the ring_clr edge re-evaluates every stage so
      // the model settles to a consistent static state after reset.
      always @(stage_in or ring_clr_q) stage_out <= #(STAGE_DELAY_PS) stage_in;
`endif
      assign ring[i] = stage_out;
   end

   assign o_pulse = ring[LENGTH-1];

   // Ring-edge counter in the ring domain, cleared from the i_clk domain.
   always_ff @(posedge o_pulse or posedge ring_clr_q) begin
      if (ring_clr_q) begin
         edge_cnt_q <= '0;
      end else if (ring_en_q) begin
`ifdef RO_OVERFLOW_EN
         if (edge_cnt_q != '1) edge_cnt_q <= edge_cnt_q + COUNT_WIDTH'(1);
`else
         edge_cnt_q <= edge_cnt_q + COUNT_WIDTH'(1);
`endif
      end
   end

   assign o_busy    = (state_q != StIdle);
   assign o_valid   = valid_q;
   assign o_count   = count_q;
   assign o_ring_en = ring_en_q;
`ifdef RO_OVERFLOW_EN
   assign o_overflow = overflow_q;
`endif

endmodule

// File: tb/tb_ring_osc_counter.sv
`timescale 1ps/1ps
// tb_ring_osc_counter: table vectors, randomized windows against an arithmetic
// model (count = window / ring period, +-1 edge), plus multi-cycle corner cases.
module tb_ring_osc_counter;

   localparam int unsigned LENGTH = 9;
   localparam int unsigned CW     = 12;
   localparam int unsigned CW2    = 6;
   localparam int unsigned GW     = 8;
   localparam int unsigned S      = 4;
   localparam int unsigned D      = 100;
   localparam int CLK_PS  = 10000;
   localparam int RING_PS = 2 * LENGTH * D;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0, cont = 1'b0;
   logic [GW-1:0] gate = '0;
   logic busy, valid, ring_en, pulse;
   logic [CW-1:0] count;
   logic start2 = 1'b0;
   logic [GW-1:0] gate2 = '0;
   logic busy2, valid2, ring_en2, pulse2;
   logic [CW2-1:0] count2;
`ifdef RO_OVERFLOW_EN
   logic ovf, ovf2;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int vq_cyc[$];
   int vq_cnt[$];
   int en_total = 0;
   int busy_total = 0;
   int last_lo = 0, last_hi = 0;

   ring_osc_counter #(.LENGTH(LENGTH), .COUNT_WIDTH(CW), .GATE_WIDTH(GW),
                      .SETTLE_CYCLES(S), .STAGE_DELAY_PS(D)) dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_gate_cycles(gate),
      .i_continuous(cont), .o_busy(busy), .o_valid(valid), .o_count(count),
`ifdef RO_OVERFLOW_EN
      .o_overflow(ovf),
`endif
      .o_ring_en(ring_en), .o_pulse(pulse)
   );

   ring_osc_counter #(.LENGTH(LENGTH), .COUNT_WIDTH(CW2), .GATE_WIDTH(GW),
                      .SETTLE_CYCLES(S), .STAGE_DELAY_PS(D)) dut2 (
      .i_clk(clk), .i_reset(reset), .i_start(start2), .i_gate_cycles(gate2),
      .i_continuous(1'b0), .o_busy(busy2), .o_valid(valid2), .o_count(count2),
`ifdef RO_OVERFLOW_EN
      .o_overflow(ovf2),
`endif
      .o_ring_en(ring_en2), .o_pulse(pulse2)
   );

   always #(CLK_PS/2) clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every result pulse and tally enable/busy cycles, sampled mid-cycle.
   always @(negedge clk) begin
      if (valid) begin
         vq_cyc.push_back(cyc);
         vq_cnt.push_back(int'(count));
      end
      if (ring_en) en_total <= en_total + 1;
      if (busy) busy_total <= busy_total + 1;
   end

   function automatic void chk(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endfunction

   function automatic void chk_rng(input string name, input int got, input int lo, input int hi);
      n_cmp++;
      if (got < lo || got > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
      end
   endfunction

   function automatic int model_edges(input int g);
      return (g * CLK_PS) / RING_PS;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One single-shot measurement started in the current cycle.
   task automatic measure(input string tag, input int g, input int poke, input bit noise,
                          input int lat, input int lo, input int hi);
      int c, q0, e0, b0, n;
      q0 = vq_cyc.size();
      e0 = en_total;
      b0 = busy_total;
      c = cyc;
      start = 1'b1;
      gate = GW'(g);
      step();
      start = 1'b0;
      n = 0;
      while (busy && n < 600) begin
         if (noise) begin
            gate  = GW'($urandom);
            start = 1'($urandom_range(0, 1));
         end
         if (cyc == c + poke) start = 1'b1;
         step();
         start = 1'b0;
         n++;
      end
      chk({tag, " finished"}, int'(n < 600), 1);
      chk({tag, " valid pulses"}, vq_cyc.size() - q0, 1);
      if (vq_cyc.size() > q0) begin
         chk({tag, " latency"}, vq_cyc[q0] - c, lat);
         chk_rng({tag, " count"}, vq_cnt[q0], lo, hi);
         chk_rng({tag, " o_count held"}, int'(count), lo, hi);
      end
      chk({tag, " ring_en cycles"}, en_total - e0, g);
      chk({tag, " busy cycles"}, busy_total - b0, g + int'(S) + 2);
      chk({tag, " idle cycle"}, cyc - c, lat + 1);
      last_lo = lo;
      last_hi = hi;
   endtask

   typedef struct {
      int g;
      int poke;
      int lat;
      int lo;
      int hi;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int c, q0, b0, n, g, e;

      // Hand-derived: latency 2+G+4, edges = floor(G*10ns / 1.8ns) +-1.
      vecs[0] = '{1,   -1, 7,   4,    6};
      vecs[1] = '{2,   -1, 8,   10,   12};
      vecs[2] = '{16,  -1, 22,  87,   89};
      vecs[3] = '{8,   -1, 14,  43,   45};
      vecs[4] = '{9,   -1, 15,  49,   51};
      vecs[5] = '{100, -1, 106, 554,  556};
      vecs[6] = '{255, -1, 261, 1415, 1417};
      vecs[7] = '{16,  19, 22,  87,   89};   // extra start pulse during SETTLE

      repeat (3) step();
      chk("reset busy", int'(busy), 0);
      chk("reset valid", int'(valid), 0);
      chk("reset count", int'(count), 0);
      chk("reset ring_en", int'(ring_en), 0);
`ifdef RO_OVERFLOW_EN
      chk("reset overflow", int'(ovf), 0);
`endif
      reset = 1'b0;
      repeat (2) step();

      for (int i = 0; i < 8; i++) begin
         measure($sformatf("vec%0d", i), vecs[i].g, vecs[i].poke, 1'b0,
                 vecs[i].lat, vecs[i].lo, vecs[i].hi);
         repeat (2) step();
      end

      // Zero window: start is ignored and the previous result is kept.
      q0 = vq_cyc.size();
      b0 = busy_total;
      start = 1'b1;
      gate = '0;
      step();
      start = 1'b0;
      repeat (5) step();
      chk("zero gate busy cycles", busy_total - b0, 0);
      chk("zero gate valids", vq_cyc.size() - q0, 0);
      chk_rng("zero gate count kept", int'(count), last_lo, last_hi);

      // Random windows with start/gate noise while busy.
      for (int i = 0; i < 8; i++) begin
         g = int'($urandom_range(1, 40));
         e = model_edges(g);
         measure($sformatf("rand%0d g=%0d", i, g), g, -1, 1'b1, 2 + g + int'(S), e - 1, e + 1);
         step();
      end

      // Continuous mode, G=8, dropped in the third RUN phase.
      q0 = vq_cyc.size();
      c = cyc;
      cont = 1'b1;
      start = 1'b1;
      gate = 8'd8;
      step();
      start = 1'b0;
      while (cyc < c + 60) begin
         if (cyc == c + 32) cont = 1'b0;
         step();
      end
      chk("cont valid pulses", vq_cyc.size() - q0, 3);
      for (int k = 0; k < 3; k++) begin
         if (vq_cyc.size() > q0 + k) begin
            chk($sformatf("cont latency %0d", k), vq_cyc[q0+k] - c, 14 * (k + 1));
            chk_rng($sformatf("cont count %0d", k), vq_cnt[q0+k], 43, 45);
         end
      end
      chk("cont idle after", int'(busy), 0);

      // Reset in the fifth RUN cycle of a G=16 window.
      q0 = vq_cyc.size();
      c = cyc;
      start = 1'b1;
      gate = 8'd16;
      step();
      start = 1'b0;
      while (cyc < c + 6) step();
      chk("pre-reset ring_en", int'(ring_en), 1);
      reset = 1'b1;
      step();
      chk("mid reset ring_en", int'(ring_en), 0);
      chk("mid reset busy", int'(busy), 0);
      chk("mid reset count", int'(count), 0);
      chk("mid reset valid", int'(valid), 0);
      reset = 1'b0;
      repeat (3) step();
      chk("mid reset no valid", vq_cyc.size() - q0, 0);
      measure("after reset", 16, -1, 1'b0, 22, 87, 89);

      // Narrow counter: G=64 gives about 355 edges.
      e = model_edges(64);
      start2 = 1'b1;
      gate2 = 8'd64;
      step();
      start2 = 1'b0;
      n = 0;
      while (!valid2 && n < 200) begin
         step();
         n++;
      end
      chk("narrow finished", int'(n), 69);
`ifdef RO_OVERFLOW_EN
      chk("narrow saturated count", int'(count2), 63);
      chk("narrow overflow", int'(ovf2), 1);
`else
      chk_rng("narrow wrapped count", int'(count2), (e % 64) - 1, (e % 64) + 1);
`endif
      repeat (2) step();
      start2 = 1'b1;
      gate2 = 8'd8;
      step();
      start2 = 1'b0;
      n = 0;
      while (!valid2 && n < 200) begin
         step();
         n++;
      end
      chk("narrow g8 finished", int'(n), 13);
      chk_rng("narrow g8 count", int'(count2), 43, 45);
`ifdef RO_OVERFLOW_EN
      chk("narrow g8 overflow", int'(ovf2), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
